// File: rtl/fixed_point_pkg.sv
// Shared word format and constants for the sign-magnitude Q8.8 multiplier.
package fixed_point_pkg;

   localparam int unsigned FRAC_W  = 8;
   localparam int unsigned MAG_W   = 15;
   localparam logic [14:0] MAX_MAG = 15'h7FFF;

   // Sign-magnitude Q8.8 word: {sign, integer magnitude, fraction}
   typedef struct packed {
      logic       sign;
      logic [6:0] int_part;
      logic [7:0] frac;
   } fxp_t;

   // Magnitude field of a word, ignoring its sign
   function automatic logic [14:0] fxp_mag(input fxp_t v);
      return {v.int_part, v.frac};
   endfunction

endpackage

// File: rtl/fixed_point_math_if.sv
// Operand/result bundle for fixed_point_math. The slave modport is the multiplier;
// the master modport is whoever supplies operands and consumes results.
interface fixed_point_math_if;

   logic        in_valid;
   logic [15:0] input1;
   logic [15:0] input2;
   logic        out_valid;
   logic [15:0] product;
   logic        overflow;

   modport master (
      output in_valid, input1, input2,
      input  out_valid, product, overflow
   );

   modport slave (
      input  in_valid, input1, input2,
      output out_valid, product, overflow
   );

endinterface

// File: rtl/fxp_mag_mult.sv
// Combinational magnitude multiplier: 15x15 product, scale by 2^-8, saturate.
// Define FIXED_POINT_ROUND_EN to round half away from zero instead of truncating.
module fxp_mag_mult
   import fixed_point_pkg::*;
(
   input  logic [14:0] a_mag,
   input  logic [14:0] b_mag,
   output logic [14:0] mag,
   output logic        ovf
);

   logic [30:0] prod_full;
   logic [30:0] scaled;

   // Full product, optional rounding bias, scale, then saturate
   always_comb begin
      prod_full = 31'(a_mag) * 31'(b_mag);
`ifdef FIXED_POINT_ROUND_EN
      // Bias of half an LSB; magnitudes are unsigned so this rounds away from zero
      prod_full = prod_full + 31'h80;
`else
      prod_full = prod_full + 31'h0;
`endif
      scaled = prod_full >> FRAC_W;
      if (scaled > 31'(MAX_MAG)) begin
         mag = MAX_MAG;
         ovf = 1'b1;
      end else begin
         mag = scaled[14:0];
         ovf = 1'b0;
      end
   end

endmodule

// File: rtl/fixed_point_math.sv
// Sign-magnitude Q8.8 multiplier with one cycle of latency.
// Optional build macro: FIXED_POINT_ROUND_EN (round instead of truncate).
module fixed_point_math
   import fixed_point_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fixed_point_math_if.slave  bus
);

   fxp_t        op_a;
   fxp_t        op_b;
   logic [14:0] res_mag;
   logic        res_ovf;
   logic        res_sign;

   logic [15:0] product_q;
   logic [15:0] product_d;
   logic        overflow_q;
   logic        overflow_d;
   logic        out_valid_q;

   assign op_a = fxp_t'(bus.input1);
   assign op_b = fxp_t'(bus.input2);

   fxp_mag_mult u_mag_mult (
      .a_mag (fxp_mag(op_a)),
      .b_mag (fxp_mag(op_b)),
      .mag   (res_mag),
      .ovf   (res_ovf)
   );

   // Result sign with negative zero folded to +0; hold outputs when no new operands
   always_comb begin
      res_sign = op_a.sign ^ op_b.sign;
      if (res_mag == 15'd0) begin
         res_sign = 1'b0;
      end
      product_d  = product_q;
      overflow_d = overflow_q;
      if (bus.in_valid) begin
         product_d  = {res_sign, res_mag};
         overflow_d = res_ovf;
      end
   end

   // Output registers, cleared asynchronously so reset is visible without a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product_q   <= 16'h0000;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         overflow_q  <= overflow_d;
         out_valid_q <= bus.in_valid;
      end
   end

   assign bus.product   = product_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_point_math.sv
// Self-checking bench for fixed_point_math: directed literal vectors plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_fixed_point_math;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fixed_point_math_if bus ();

   fixed_point_math dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on sign/magnitude values, returns {ovf, word}
   function automatic logic [16:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
      longint unsigned ma;
      longint unsigned mb;
      longint unsigned p;
      logic            s;
      logic            o;
      ma = longint'(a & 16'h7FFF);
      mb = longint'(b & 16'h7FFF);
      p  = ma * mb;
`ifdef FIXED_POINT_ROUND_EN
      p = p + 128;
`endif
      p = p / 256;
      o = 1'b0;
      if (p > 32767) begin
         p = 32767;
         o = 1'b1;
      end
      s = a[15] ^ b[15];
      if (p == 0) s = 1'b0;
      return {o, s, p[14:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the registered outputs
   logic        m_valid;
   logic [15:0] m_product;
   logic        m_overflow;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid    <= 1'b0;
         m_product  <= 16'h0000;
         m_overflow <= 1'b0;
      end else begin
         m_valid <= bus.in_valid;
         if (bus.in_valid) begin
            {m_overflow, m_product} <= ref_mult(bus.input1, bus.input2);
         end
      end
   end

   // Compare process: outputs are defined on every cycle, including reset
   always @(negedge clk) begin
      chk("model_cycle", {15'd0, bus.out_valid, bus.overflow, bus.product},
          {15'd0, m_valid, m_overflow, m_product});
   end

   // Drive one valid operand pair, check the registered result after the edge
   task automatic vec(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ep, input logic eo);
      chk({name, "_model"}, {15'd0, ref_mult(a, b)}, {15'd0, eo, ep});
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.input1   = a;
      bus.input2   = b;
      @(posedge clk);
      #1;
      chk(name, {15'd0, bus.out_valid, bus.overflow, bus.product}, {15'd0, 1'b1, eo, ep});
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.input1   = 16'h0000;
      bus.input2   = 16'h0000;
      #1;
      chk("reset_state", {15'd0, bus.out_valid, bus.overflow, bus.product}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      vec("quarter",      16'h0080, 16'h0080, 16'h0040, 1'b0);
      vec("one_x_half",   16'h0100, 16'h0080, 16'h0080, 1'b0);
      vec("three_sq",     16'h0300, 16'h0300, 16'h0900, 1'b0);
      vec("neg_x_pos",    16'h8300, 16'h0300, 16'h8900, 1'b0);
      vec("neg_x_neg",    16'h8300, 16'h8300, 16'h0900, 1'b0);
      vec("tiny",         16'h0001, 16'h0001, 16'h0000, 1'b0);
      vec("neg_tiny",     16'h8001, 16'h0001, 16'h0000, 1'b0);
`ifdef FIXED_POINT_ROUND_EN
      vec("half_lsb",     16'h0080, 16'h0001, 16'h0001, 1'b0);
`else
      vec("half_lsb",     16'h0080, 16'h0001, 16'h0000, 1'b0);
`endif
      vec("sat_pos",      16'h7F00, 16'h0200, 16'h7FFF, 1'b1);
      vec("sat_neg",      16'hFF00, 16'h0200, 16'hFFFF, 1'b1);
      vec("neg_zero_in",  16'h8000, 16'h0300, 16'h0000, 1'b0);

      // Idle cycle: out_valid drops, product holds
      vec("pre_hold",     16'h0300, 16'h0300, 16'h0900, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.input1   = 16'h1234;
      bus.input2   = 16'h0567;
      @(posedge clk);
      #1;
      chk("hold", {15'd0, bus.out_valid, bus.overflow, bus.product}, {15'd0, 1'b0, 1'b0, 16'h0900});

      // Reset mid-stream: asynchronous clear, valid input that cycle discarded
      vec("pre_reset",    16'h0200, 16'h0300, 16'h0600, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.input1   = 16'h7F00;
      bus.input2   = 16'h0200;
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {15'd0, bus.out_valid, bus.overflow, bus.product}, 32'd0);
      @(posedge clk);
      #1;
      chk("reset_hold", {15'd0, bus.out_valid, bus.overflow, bus.product}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      vec("post_reset",   16'h0100, 16'h8100, 16'h8100, 1'b0);

      // Randomized traffic, mostly in the non-saturating range
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.input1 = 16'($urandom);
            bus.input2 = 16'($urandom);
         end else begin
            bus.input1 = {1'($urandom), 15'($urandom_range(0, 16'h0FFF))};
            bus.input2 = {1'($urandom), 15'($urandom_range(0, 16'h0FFF))};
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
